// File: rtl/filtros_pkg.sv
// Shared types and constants for the image streaming blocks.
// Holds the reader FSM encoding, bus widths and the default frame geometry.
package filtros_pkg;

    localparam int ADDR_W = 32;
    localparam int PIX_W  = 8;

    localparam logic [ADDR_W-1:0] DEF_BASE_ADDR  = 32'd0;
    localparam logic [31:0]       DEF_NUM_PIXELS = 32'd65536;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/pixel_fifo2.sv
// Two-entry pixel FIFO with occupancy count and full/empty flags.
// Reads of an empty FIFO are ignored; the writer never pushes into a full FIFO.
module pixel_fifo2
    import filtros_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [PIX_W-1:0] rd_data,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [PIX_W-1:0] mem_q [2];
    logic [PIX_W-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             rd_ok;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign rd_ok   = rd_en && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (rd_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({wr_en, rd_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/image_reader.sv
// Streams one frame of 8-bit pixels from a read-only memory port onto a
// valid/ready pixel stream, keeping at most two pixels buffered or in flight.
module image_reader
    import filtros_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter logic [31:0]       NUM_PIXELS = DEF_NUM_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [PIX_W-1:0]  mem_q,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output state_e            dbg_state,
    output logic [1:0]        dbg_fifo_count
);

    localparam logic [31:0] LAST_IDX = NUM_PIXELS - 32'd1;

    state_e      state_q, state_d;
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] out_cnt_q, out_cnt_d;
    logic        inflight_q, inflight_d;

    logic        fifo_full, fifo_empty;
    logic        pop, credit, issue, last_hs;

    // Stream handshake: a pixel transfers on a rising edge where pix_valid and
    // pix_ready are both high; while valid is held without ready, pix_data and
    // pix_last do not change, and valid never drops before the transfer.
    assign pix_valid = !fifo_empty;
    assign pop       = pix_valid && pix_ready;
    assign pix_last  = pix_valid && (out_cnt_q == LAST_IDX);
    assign last_hs   = pop && pix_last;

    // Issue only if the FIFO, after this cycle's pop, has room for every
    // outstanding read plus the new one.
    assign credit = inflight_q ? (fifo_empty || (pop && !fifo_full))
                               : !(fifo_full && !pop);
    assign issue  = (state_q == READ) && credit;

    assign mem_rd    = issue;
    assign mem_addr  = BASE_ADDR + issue_cnt_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        inflight_d  = issue;
        if (pop) begin
            out_cnt_d = out_cnt_q + 32'd1;
        end
        case (state_q)
            IDLE: begin
                if (start) state_d = READ;
            end
            READ: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + 32'd1;
                    if (issue_cnt_q == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) state_d = FINISH;
            end
            FINISH: begin
                state_d     = IDLE;
                issue_cnt_d = '0;
                out_cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= inflight_d;
        end
    end

    // Read data returns one cycle after issue and is captured unconditionally.
    pixel_fifo2 u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_q),
        .wr_data (mem_q),
        .rd_en   (pop),
        .rd_data (pix_data),
        .count   (dbg_fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_image_reader.sv
// Scoreboard bench for image_reader: three instances (4-pixel frame at 0x100,
// 1-pixel frame, 4-pixel frame wrapping the 32-bit address space).
module tb_image_reader;
    import filtros_pkg::*;

    localparam logic [31:0] BASE0 = 32'h0000_0100;
    localparam logic [31:0] BASE1 = 32'h0000_0100;
    localparam logic [31:0] BASE2 = 32'hFFFF_FFFE;

    logic        clk;
    logic        rst;
    logic        pix_ready;
    logic [2:0]  start_v;
    logic [2:0]  busy_v, done_v, mem_rd_v, pix_valid_v, pix_last_v;
    logic [31:0] mem_addr_a [3];
    logic [7:0]  mem_q_a [3];
    logic [7:0]  pix_data_a [3];
    state_e      dbg_state_a [3];
    logic [1:0]  dbg_cnt_a [3];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_mode = 0;
    int rdy_ph = 0;

    logic [10:0] exp_q[$];
    logic [33:0] addr_q[$];

    int   rd_total [3];
    int   hs_total [3];
    int   done_cnt [3];
    int   exp_done [3];
    int   frame_hs [3];
    int   first_hs_cyc [3];
    int   last_hs_cyc [3];
    logic prev_stall [3];
    logic [7:0] prev_data [3];
    logic prev_last [3];
    logic prev_last_hs [3];

    image_reader #(.BASE_ADDR(BASE0), .NUM_PIXELS(32'd4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .mem_addr(mem_addr_a[0]), .mem_rd(mem_rd_v[0]), .mem_q(mem_q_a[0]),
        .pix_data(pix_data_a[0]), .pix_valid(pix_valid_v[0]), .pix_ready(pix_ready),
        .pix_last(pix_last_v[0]), .dbg_state(dbg_state_a[0]), .dbg_fifo_count(dbg_cnt_a[0]));

    image_reader #(.BASE_ADDR(BASE1), .NUM_PIXELS(32'd1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .mem_addr(mem_addr_a[1]), .mem_rd(mem_rd_v[1]), .mem_q(mem_q_a[1]),
        .pix_data(pix_data_a[1]), .pix_valid(pix_valid_v[1]), .pix_ready(pix_ready),
        .pix_last(pix_last_v[1]), .dbg_state(dbg_state_a[1]), .dbg_fifo_count(dbg_cnt_a[1]));

    image_reader #(.BASE_ADDR(BASE2), .NUM_PIXELS(32'd4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .mem_addr(mem_addr_a[2]), .mem_rd(mem_rd_v[2]), .mem_q(mem_q_a[2]),
        .pix_data(pix_data_a[2]), .pix_valid(pix_valid_v[2]), .pix_ready(pix_ready),
        .pix_last(pix_last_v[2]), .dbg_state(dbg_state_a[2]), .dbg_fifo_count(dbg_cnt_a[2]));

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] base_of(input int k);
        case (k)
            0:       return BASE0;
            1:       return BASE1;
            default: return BASE2;
        endcase
    endfunction

    function automatic logic [7:0] pix_byte(input logic [1:0] i);
        return 8'h11 * ({6'd0, i} + 8'd1);
    endfunction

    // Image bytes 11,22,33,44 at the base; everything else reads as EE.
    function automatic logic [7:0] mem_byte(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        if (off < 32'd4) return pix_byte(off[1:0]);
        return 8'hEE;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) mem_q_a[k] <= mem_byte(mem_addr_a[k], base_of(k));
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: pix_ready = 1'b1;
            1: begin
                pix_ready = (rdy_ph == 0);
                rdy_ph = (rdy_ph + 1) % 3;
            end
            default: pix_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                rd_total[k] = 0;
                hs_total[k] = 0;
                prev_stall[k] = 1'b0;
                prev_last_hs[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (mem_rd_v[k]) begin
                    rd_total[k]++;
                    chk("rd_expected", 64'(addr_q.size() != 0), 64'd1);
                    if (addr_q.size() != 0) begin
                        chk("rd_instance", 64'(k), 64'(addr_q[0][33:32]));
                        chk("mem_addr", 64'(mem_addr_a[k]), 64'(addr_q[0][31:0]));
                        void'(addr_q.pop_front());
                    end
                end
                if (prev_stall[k]) begin
                    chk("hold_valid", 64'(pix_valid_v[k]), 64'd1);
                    chk("hold_data", 64'(pix_data_a[k]), 64'(prev_data[k]));
                    chk("hold_last", 64'(pix_last_v[k]), 64'(prev_last[k]));
                end
                if (pix_valid_v[k] && pix_ready) begin
                    hs_total[k]++;
                    if (frame_hs[k] == 0) first_hs_cyc[k] = cyc;
                    last_hs_cyc[k] = cyc;
                    frame_hs[k]++;
                    chk("pixel_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        chk("pixel", 64'({k[1:0], pix_last_v[k], pix_data_a[k]}), 64'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                end
                if (mem_rd_v[k]) chk("occupancy_le2", 64'((rd_total[k] - hs_total[k]) <= 2), 64'd1);
                if (done_v[k]) begin
                    done_cnt[k]++;
                    chk("done_after_last", 64'(prev_last_hs[k]), 64'd1);
                end
                prev_last_hs[k] = pix_valid_v[k] && pix_ready && pix_last_v[k];
                prev_stall[k] = pix_valid_v[k] && !pix_ready;
                prev_data[k]  = pix_data_a[k];
                prev_last[k]  = pix_last_v[k];
            end
        end
    end

    // Driver tasks
    task automatic check_reset_outputs(input int k);
        chk("rst_busy", 64'(busy_v[k]), 64'd0);
        chk("rst_done", 64'(done_v[k]), 64'd0);
        chk("rst_mem_rd", 64'(mem_rd_v[k]), 64'd0);
        chk("rst_pix_valid", 64'(pix_valid_v[k]), 64'd0);
        chk("rst_pix_last", 64'(pix_last_v[k]), 64'd0);
        chk("rst_pix_data", 64'(pix_data_a[k]), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr_a[k]), 64'(base_of(k)));
        chk("rst_state", 64'(dbg_state_a[k]), 64'(IDLE));
    endtask

    task automatic queue_frame(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({k[1:0], (i == n - 1), pix_byte(i[1:0])});
            addr_q.push_back({k[1:0], base_of(k) + i});
        end
        exp_done[k]++;
        frame_hs[k] = 0;
    endtask

    task automatic start_frame(input int k, input int n);
        queue_frame(k, n);
        @(posedge clk); #1 start_v[k] = 1'b1;
        @(posedge clk); #1 start_v[k] = 1'b0;
        chk("busy_after_start", 64'(busy_v[k]), 64'd1);
    endtask

    task automatic wait_done(input int k);
        int t;
        t = 0;
        while (done_v[k] !== 1'b1 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("frame_done_seen", 64'(done_v[k]), 64'd1);
        @(posedge clk); #1;
        chk("busy_after_done", 64'(busy_v[k]), 64'd0);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int t;
        int r0;
        int h0;
        rst = 1'b0;
        start_v = 3'b000;
        pix_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rd_total[k] = 0; hs_total[k] = 0; done_cnt[k] = 0; exp_done[k] = 0;
            frame_hs[k] = 0; first_hs_cyc[k] = 0; last_hs_cyc[k] = 0;
            prev_stall[k] = 1'b0; prev_data[k] = 8'd0; prev_last[k] = 1'b0; prev_last_hs[k] = 1'b0;
        end
        #2;
        for (int k = 0; k < 3; k++) check_reset_outputs(k);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full-rate frame: 11,22,33,44 on consecutive cycles
        ready_mode = 0;
        start_frame(0, 4);
        wait_done(0);
        chk("burst_span", 64'(last_hs_cyc[0] - first_hs_cyc[0]), 64'd3);

        // Ready pattern 1,0,0 repeating
        rdy_ph = 0;
        ready_mode = 1;
        start_frame(0, 4);
        wait_done(0);
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Ready held low for 10 cycles after start
        ready_mode = 2;
        @(posedge clk); #1;
        r0 = rd_total[0];
        start_frame(0, 4);
        repeat (9) @(posedge clk);
        #1;
        chk("stall_rd_pulses", 64'(rd_total[0] - r0), 64'd2);
        chk("stall_valid", 64'(pix_valid_v[0]), 64'd1);
        chk("stall_data", 64'(pix_data_a[0]), 64'h11);
        ready_mode = 0;
        wait_done(0);

        // Reset after the second handshake, then replay
        h0 = hs_total[0];
        start_frame(0, 4);
        t = 0;
        while ((hs_total[0] - h0) < 2 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("two_handshakes", 64'((hs_total[0] - h0) >= 2), 64'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs(0);
        exp_q.delete();
        addr_q.delete();
        exp_done[0]--;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_reset", 64'(pix_valid_v[0]), 64'd0);
        start_frame(0, 4);
        wait_done(0);

        // Single-pixel frame with start held high for the whole frame
        queue_frame(1, 1);
        @(posedge clk); #1 start_v[1] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            start_v[1] = busy_v[1];
            if (!busy_v[1]) break;
        end
        start_v[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("single_busy_idle", 64'(busy_v[1]), 64'd0);
        chk("single_done_count", 64'(done_cnt[1]), 64'd1);
        chk("single_pixels", 64'(frame_hs[1]), 64'd1);

        // Address wrap at the top of the 32-bit space
        start_frame(2, 4);
        wait_done(2);
        chk("wrap_burst_span", 64'(last_hs_cyc[2] - first_hs_cyc[2]), 64'd3);

        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("done_count", 64'(done_cnt[k]), 64'(exp_done[k]));
        chk("addr_q_drained", 64'(addr_q.size()), 64'd0);
        chk("final_exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
